// File: rtl/pe_row_group.sv
// pe_row_group: 5x5 signed conv row stage; five row dot-products per window, 2-cycle pipeline.
module pe_row_group #(
  parameter int PIX_W = 8,
  parameter int W_W   = 8,
  parameter int FRAC  = 7,
  parameter int SUM_W = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     w_we,
  input  logic [4:0]               w_addr,
  input  logic [W_W-1:0]           w_data,
  input  logic                     start,
  input  logic                     row_start,
  input  logic                     pix_valid,
  input  logic [5*PIX_W-1:0]       pix_col,
  input  logic                     frame_end,
  output logic signed [SUM_W-1:0]  sum1,
  output logic signed [SUM_W-1:0]  sum2,
  output logic signed [SUM_W-1:0]  sum3,
  output logic signed [SUM_W-1:0]  sum4,
  output logic signed [SUM_W-1:0]  sum5,
  output logic                     wb_en,
  output logic                     FinishFlag,
  output logic                     busy
);
  localparam int P_W = PIX_W + W_W - FRAC;
  typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;
  state_t state;
  logic [2:0] fill;
  logic [5*PIX_W-1:0] win [5];
  logic signed [W_W-1:0] wt [25];
  logic signed [P_W-1:0] p [25];
  logic signed [SUM_W-1:0] s [5];
  logic signed [SUM_W-1:0] rs [5];
  logic v0, v1, act, issue;
  function automatic logic signed [P_W-1:0] mulq(input logic signed [PIX_W-1:0] a,
                                                 input logic signed [W_W-1:0] b);
    logic signed [PIX_W+W_W-1:0] m;
    m = (PIX_W+W_W)'(a) * (PIX_W+W_W)'(b);
    return P_W'(m >>> FRAC);
  endfunction
  assign act   = (state == FILL || state == RUN) && pix_valid;
  assign issue = act && !row_start && (state == RUN || fill == 3'd4);
  assign busy  = state != IDLE;
  assign {sum1, sum2, sum3, sum4, sum5} = {s[0], s[1], s[2], s[3], s[4]};
  always_comb begin
    for (int r = 0; r < 5; r++) begin
      rs[r] = '0;
      for (int c = 0; c < 5; c++) rs[r] = rs[r] + SUM_W'(p[r*5+c]);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      fill <= '0;
      {v0, v1, wb_en, FinishFlag} <= '0;
      for (int i = 0; i < 5; i++) win[i] <= '0;
      for (int i = 0; i < 5; i++) s[i] <= '0;
      for (int i = 0; i < 25; i++) wt[i] <= '0;
      for (int i = 0; i < 25; i++) p[i] <= '0;
    end else begin
      v0 <= issue;
      v1 <= v0;
      wb_en <= v1;
      FinishFlag <= 1'b0;
      for (int i = 0; i < 25; i++) p[i] <= mulq(win[i%5][(i/5)*PIX_W +: PIX_W], wt[i]);
      if (v1) for (int r = 0; r < 5; r++) s[r] <= rs[r];
      case (state)
        IDLE: begin
          if (w_we && w_addr < 5'd25) wt[w_addr] <= w_data;
          if (start) begin
            state <= FILL;
            fill <= '0;
          end
        end
        FILL, RUN: begin
          // a new output row restarts the window so no window straddles two rows
          if (act && row_start) begin
            for (int i = 0; i < 4; i++) win[i] <= '0;
            win[4] <= pix_col;
            fill <= 3'd1;
            state <= FILL;
          end else if (act) begin
            for (int i = 0; i < 4; i++) win[i] <= win[i+1];
            win[4] <= pix_col;
            if (state == FILL) fill <= fill + 3'd1;
            if (state == FILL && fill == 3'd4) state <= RUN;
          end
          if (frame_end) state <= DRAIN;
        end
        DRAIN: begin
          if (!v0 && !v1) begin
            FinishFlag <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pe_row_group.sv
// tb_pe_row_group: scoreboard bench; a bench-side window/weight model predicts every wb_en.
module tb_pe_row_group;
  logic clk = 0, rst = 1, w_we = 0, start = 0, row_start = 0, pix_valid = 0, frame_end = 0;
  logic [4:0] w_addr = '0;
  logic [7:0] w_data = '0;
  logic [39:0] pix_col = '0;
  logic signed [10:0] sum1, sum2, sum3, sum4, sum5;
  logic wb_en, FinishFlag, busy;

  pe_row_group dut (
    .clk(clk), .rst(rst), .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .start(start),
    .row_start(row_start), .pix_valid(pix_valid), .pix_col(pix_col), .frame_end(frame_end),
    .sum1(sum1), .sum2(sum2), .sum3(sum3), .sum4(sum4), .sum5(sum5),
    .wb_en(wb_en), .FinishFlag(FinishFlag), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0][10:0] s;
    int due;
  } exp_t;
  exp_t q[$];
  int pass_n = 0, tot_n = 0, cyc = 0, pulses = 0, last_wb = 0, tf = 0;
  int wm [25];
  logic [39:0] tw [5];
  bit tb_act = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    tot_n++;
    if (got == exp) pass_n++;
    else $display("FAIL %s got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int erow(input int r);
    int acc = 0;
    for (int c = 0; c < 5; c++) acc += (int'($signed(tw[c][8*r +: 8])) * wm[r*5+c]) >>> 7;
    return acc;
  endfunction

  always @(negedge clk) begin
    if (wb_en) begin
      exp_t e;
      pulses++;
      last_wb = cyc;
      if (q.size() == 0) chk("spurious_wb", 1, 0);
      else begin
        e = q.pop_front();
        chk("latency", cyc, e.due);
        chk("sum1", sum1, int'($signed(e.s[0])));
        chk("sum2", sum2, int'($signed(e.s[1])));
        chk("sum3", sum3, int'($signed(e.s[2])));
        chk("sum4", sum4, int'($signed(e.s[3])));
        chk("sum5", sum5, int'($signed(e.s[4])));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_w(input int a, input int d);
    w_we = 1;
    w_addr = 5'(a);
    w_data = 8'(d);
    if (a < 25) wm[a] = int'($signed(w_data));
    tick;
    w_we = 0;
  endtask

  task automatic start_frame;
    start = 1;
    tick;
    start = 0;
    tb_act = 1;
    tf = 0;
    pulses = 0;
  endtask

  task automatic col(input logic [39:0] c, input bit rs, input bit fe);
    exp_t e;
    pix_valid = 1;
    pix_col = c;
    row_start = rs;
    frame_end = fe;
    if (tb_act) begin
      if (rs) begin
        for (int i = 0; i < 4; i++) tw[i] = '0;
        tf = 1;
      end else begin
        for (int i = 0; i < 4; i++) tw[i] = tw[i+1];
        tf++;
      end
      tw[4] = c;
      if (!rs && tf >= 5) begin
        for (int r = 0; r < 5; r++) e.s[r] = 11'(erow(r));
        e.due = cyc + 3;
        q.push_back(e);
      end
    end
    if (fe) tb_act = 0;
    tick;
    {pix_valid, row_start, frame_end} = '0;
  endtask

  task automatic wait_done(input int exp_pulses);
    bit seen = 0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      seen = FinishFlag;
    end
    chk("finish_seen", seen, 1);
    chk("finish_after_wb", cyc, last_wb + 1);
    chk("pulses", pulses, exp_pulses);
    @(negedge clk);
    chk("finish_pulse", FinishFlag, 0);
    chk("busy_idle", busy, 0);
    chk("sb_empty", q.size(), 0);
  endtask

  function automatic logic [39:0] rcol;
    return 40'({$urandom(), $urandom()});
  endfunction

  task automatic idle_outputs;
    @(negedge clk);
    chk("rst_sum1", sum1, 0);
    chk("rst_sum5", sum5, 0);
    chk("rst_wb", wb_en, 0);
    chk("rst_fin", FinishFlag, 0);
    chk("rst_busy", busy, 0);
  endtask

  initial begin
    logic [7:0] b;
    for (int i = 0; i < 25; i++) wm[i] = 0;
    for (int i = 0; i < 5; i++) tw[i] = '0;
    tick;
    tick;
    rst = 0;
    idle_outputs;
    pulses = 0;
    for (int k = 0; k < 7; k++) col(rcol(), 0, 0);
    repeat (4) tick;
    chk("idle_no_wb", pulses, 0);
    chk("idle_busy", busy, 0);

    for (int i = 0; i < 25; i++) load_w(i, (i % 5 == 4) ? 127 : 0);
    start_frame;
    chk("busy_run", busy, 1);
    for (int k = 0; k < 7; k++) begin
      b = 8'(k);
      col({5{b}}, 0, k == 6);
    end
    wait_done(3);

    for (int i = 0; i < 25; i++) load_w(i, 8'h80);
    start_frame;
    for (int k = 0; k < 5; k++) col({5{8'h80}}, 0, k == 4);
    wait_done(1);
    start_frame;
    for (int k = 0; k < 5; k++) col({5{8'h7f}}, 0, k == 4);
    wait_done(1);

    load_w(0, 64);
    load_w(31, 8'h55);
    start_frame;
    w_we = 1;
    w_addr = 5'd0;
    w_data = 8'h55;
    for (int k = 0; k < 8; k++) col(rcol(), 0, k == 7);
    w_we = 0;
    wait_done(4);

    for (int i = 0; i < 25; i++) load_w(i, int'($urandom_range(0, 255)));
    start_frame;
    for (int k = 0; k < 6; k++) col(rcol(), 0, 0);
    col(rcol(), 1, 0);
    for (int k = 0; k < 4; k++) col(rcol(), 0, k == 3);
    wait_done(3);

    start_frame;
    for (int k = 0; k < 5; k++) col(rcol(), 0, 0);
    rst = 1;
    q.delete();
    tb_act = 0;
    pulses = 0;
    tick;
    tick;
    rst = 0;
    idle_outputs;
    for (int k = 0; k < 6; k++) col(rcol(), 0, 0);
    repeat (4) tick;
    chk("abort_no_wb", pulses, 0);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
